// File: rtl/mem_port_arbiter_if.sv
// Single shared memory port between the arbiter (master) and the memory (slave).
// The arbiter drives the request fields; the memory returns ready and read data.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          m_valid;
    logic          m_rw;
    logic          m_ready;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;

    modport master (
        output m_valid, m_rw, m_addr, m_wdata,
        input  m_ready, m_rdata
    );

    modport slave (
        input  m_valid, m_rw, m_addr, m_wdata,
        output m_ready, m_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the core's single memory port between fetch (IF) and load/store (D).
// Fixed priority D > IF with a burst limit, registered command fields and a ready timeout.
module mem_port_arbiter #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int MAX_D_BURST = 4,
    parameter int TIMEOUT     = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                if_req,
    input  logic [AW-1:0]       if_addr,
    output logic                if_done,
    output logic [DW-1:0]       if_rdata,
    input  logic                d_req,
    input  logic                d_rw,
    input  logic [AW-1:0]       d_addr,
    input  logic [DW-1:0]       d_wdata,
    output logic                d_done,
    output logic [DW-1:0]       d_rdata,
    output logic                err,
    mem_port_arbiter_if.master  mem
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    localparam int BW = (MAX_D_BURST > 1) ? $clog2(MAX_D_BURST + 1) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_D_BURST);
    localparam logic [TW-1:0] TMO_LAST  = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit            TMO_EN    = (TIMEOUT != 0);

    logic [1:0]    state;
    logic          owner_d;
    logic          timed_out;
    logic [BW-1:0] burst_cnt;
    logic [TW-1:0] tmo_cnt;
    logic          grant_d;
    logic          grant_if;

    // D wins a contended slot until it has taken MAX_D_BURST of them in a row.
    always_comb begin
        grant_d  = d_req && (!if_req || (burst_cnt != BURST_MAX));
        grant_if = if_req && !grant_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            owner_d     <= 1'b0;
            timed_out   <= 1'b0;
            burst_cnt   <= '0;
            tmo_cnt     <= '0;
            mem.m_valid <= 1'b0;
            mem.m_rw    <= 1'b0;
            mem.m_addr  <= '0;
            mem.m_wdata <= '0;
            if_rdata    <= '0;
            d_rdata     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_d || grant_if) begin
                        owner_d     <= grant_d;
                        mem.m_addr  <= grant_d ? d_addr : if_addr;
                        mem.m_rw    <= grant_d && d_rw;
                        if (grant_d) begin
                            mem.m_wdata <= d_wdata;
                        end
                        mem.m_valid <= 1'b1;
                        tmo_cnt     <= '0;
                        timed_out   <= 1'b0;
                        state       <= ACCESS;
                        if (grant_if || !if_req) begin
                            burst_cnt <= '0;
                        end else if (burst_cnt != BURST_MAX) begin
                            burst_cnt <= burst_cnt + 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    // A ready on the final timeout cycle still counts as a normal completion.
                    if (mem.m_ready) begin
                        if (!mem.m_rw) begin
                            if (owner_d) begin
                                d_rdata <= mem.m_rdata;
                            end else begin
                                if_rdata <= mem.m_rdata;
                            end
                        end
                        mem.m_valid <= 1'b0;
                        state       <= RESP;
                    end else if (TMO_EN && (tmo_cnt == TMO_LAST)) begin
                        if (owner_d) begin
                            d_rdata <= '0;
                        end else begin
                            if_rdata <= '0;
                        end
                        mem.m_valid <= 1'b0;
                        timed_out   <= 1'b1;
                        state       <= RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign if_done = (state == RESP) && !owner_d;
    assign d_done  = (state == RESP) && owner_d;
    assign err     = (state == RESP) && timed_out;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change and outputs are sampled on the falling edge.
module tb_mem_port_arbiter;
    logic        clk;
    logic        reset_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_rw;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_done;
    logic [31:0] d_rdata;
    logic        err;
    int          checks;
    int          errors;
    logic        exp_d;

    mem_port_arbiter_if #(.AW(32), .DW(32)) mem ();

    mem_port_arbiter #(
        .AW(32), .DW(32), .MAX_D_BURST(4), .TIMEOUT(16)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
        .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata), .err(err),
        .mem(mem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] simulation did not finish");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic i_req, input logic [31:0] i_addr,
                                 input logic dq, input logic rw, input logic [31:0] da,
                                 input logic [31:0] dw, input logic rdy, input logic [31:0] rd);
        if_req       = i_req;
        if_addr      = i_addr;
        d_req        = dq;
        d_rw         = rw;
        d_addr       = da;
        d_wdata      = dw;
        mem.m_ready  = rdy;
        mem.m_rdata  = rd;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        checkOutput("rst_m_valid", 64'(mem.m_valid), 64'(0));
        checkOutput("rst_if_done", 64'(if_done), 64'(0));
        checkOutput("rst_d_done", 64'(d_done), 64'(0));
        checkOutput("rst_err", 64'(err), 64'(0));
        checkOutput("rst_m_addr", 64'(mem.m_addr), 64'(0));
        checkOutput("rst_d_rdata", 64'(d_rdata), 64'(0));
        reset_n = 1'b1;
        tick();

        $display("[TB] single IF read");
        applyStimulus(1, 32'h8, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("rd_m_valid", 64'(mem.m_valid), 64'(1));
        checkOutput("rd_m_addr", 64'(mem.m_addr), 64'(32'h8));
        checkOutput("rd_m_rw", 64'(mem.m_rw), 64'(0));
        applyStimulus(1, 32'h8, 0, 0, 0, 0, 1, 32'h00700113);
        tick();
        checkOutput("rd_if_done", 64'(if_done), 64'(1));
        checkOutput("rd_if_rdata", 64'(if_rdata), 64'(32'h00700113));
        checkOutput("rd_err", 64'(err), 64'(0));
        checkOutput("rd_d_done", 64'(d_done), 64'(0));
        checkOutput("rd_m_valid_low", 64'(mem.m_valid), 64'(0));
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("rd_if_done_single", 64'(if_done), 64'(0));

        $display("[TB] D write with delayed ready");
        applyStimulus(0, 0, 1, 1, 32'h4, 32'h15, 0, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            checkOutput("wr_m_valid", 64'(mem.m_valid), 64'(1));
            checkOutput("wr_m_rw", 64'(mem.m_rw), 64'(1));
            checkOutput("wr_m_addr", 64'(mem.m_addr), 64'(32'h4));
            checkOutput("wr_m_wdata", 64'(mem.m_wdata), 64'(32'h15));
            checkOutput("wr_d_done_early", 64'(d_done), 64'(0));
            if (i == 3) mem.m_ready = 1'b1;
            if (i == 3) mem.m_rdata = 32'hDEAD;
            tick();
        end
        checkOutput("wr_d_done", 64'(d_done), 64'(1));
        checkOutput("wr_err", 64'(err), 64'(0));
        checkOutput("wr_d_rdata_kept", 64'(d_rdata), 64'(0));
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        $display("[TB] contention, D bursts limited to four");
        applyStimulus(1, 32'h200, 1, 0, 32'h100, 0, 1, 32'h1234);
        for (int k = 0; k < 10; k++) begin
            exp_d = ((k % 5) != 4);
            tick();
            checkOutput("arb_m_valid", 64'(mem.m_valid), 64'(1));
            checkOutput("arb_m_addr", 64'(mem.m_addr), exp_d ? 64'(32'h100) : 64'(32'h200));
            tick();
            checkOutput("arb_d_done", 64'(d_done), 64'(exp_d));
            checkOutput("arb_if_done", 64'(if_done), 64'(!exp_d));
            tick();
            checkOutput("arb_idle_valid", 64'(mem.m_valid), 64'(0));
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        $display("[TB] D read timeout");
        applyStimulus(0, 0, 1, 0, 32'h40, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            tick();
            checkOutput("tmo_m_valid", 64'(mem.m_valid), 64'(1));
        end
        tick();
        checkOutput("tmo_m_valid_drop", 64'(mem.m_valid), 64'(0));
        checkOutput("tmo_d_done", 64'(d_done), 64'(1));
        checkOutput("tmo_err", 64'(err), 64'(1));
        checkOutput("tmo_d_rdata", 64'(d_rdata), 64'(0));
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("tmo_err_clear", 64'(err), 64'(0));

        $display("[TB] ready on the last timeout cycle");
        applyStimulus(0, 0, 1, 0, 32'h44, 0, 0, 32'hCAFE);
        for (int i = 1; i <= 16; i++) begin
            tick();
            checkOutput("tmo2_m_valid", 64'(mem.m_valid), 64'(1));
            if (i == 16) mem.m_ready = 1'b1;
        end
        tick();
        checkOutput("tmo2_d_done", 64'(d_done), 64'(1));
        checkOutput("tmo2_err", 64'(err), 64'(0));
        checkOutput("tmo2_d_rdata", 64'(d_rdata), 64'(32'hCAFE));
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        $display("[TB] async reset during access");
        applyStimulus(0, 0, 1, 0, 32'h80, 0, 0, 0);
        tick();
        checkOutput("ars_m_valid", 64'(mem.m_valid), 64'(1));
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("ars_m_valid_now", 64'(mem.m_valid), 64'(0));
        applyStimulus(1, 32'h88, 0, 0, 0, 0, 0, 0);
        tick();
        checkOutput("ars_d_done", 64'(d_done), 64'(0));
        checkOutput("ars_if_done", 64'(if_done), 64'(0));
        checkOutput("ars_m_valid_held", 64'(mem.m_valid), 64'(0));
        reset_n = 1'b1;
        tick();
        checkOutput("ars_if_grant", 64'(mem.m_valid), 64'(1));
        checkOutput("ars_if_addr", 64'(mem.m_addr), 64'(32'h88));
        mem.m_ready = 1'b1;
        mem.m_rdata = 32'h55;
        tick();
        checkOutput("ars_if_done_after", 64'(if_done), 64'(1));
        checkOutput("ars_if_rdata", 64'(if_rdata), 64'(32'h55));
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        $display("[TB] request held through RESP");
        applyStimulus(0, 0, 1, 0, 32'h10, 0, 1, 32'h77);
        tick();
        checkOutput("rsp_m_addr0", 64'(mem.m_addr), 64'(32'h10));
        tick();
        checkOutput("rsp_d_done", 64'(d_done), 64'(1));
        checkOutput("rsp_d_rdata", 64'(d_rdata), 64'(32'h77));
        d_addr = 32'h20;
        mem.m_rdata = 32'h99;
        tick();
        checkOutput("rsp_no_grant", 64'(mem.m_valid), 64'(0));
        checkOutput("rsp_done_once", 64'(d_done), 64'(0));
        tick();
        checkOutput("rsp_regrant", 64'(mem.m_valid), 64'(1));
        checkOutput("rsp_m_addr1", 64'(mem.m_addr), 64'(32'h20));
        tick();
        checkOutput("rsp_d_done2", 64'(d_done), 64'(1));
        checkOutput("rsp_d_rdata2", 64'(d_rdata), 64'(32'h99));
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single memory port (valid/rw/ready/addr/wdata/rdata) between two requesters: instruction fetch (IF) and data load/store (D).
- Grants one access at a time with fixed priority D > IF, bounded by an anti-starvation counter.
- Registers the address, command and write data for each access, holds them stable for the whole transaction, and returns a one-cycle done pulse with read data.
- Adds a ready timeout so a hung slave cannot lock the core.

Parameters:
AW, 32, address width
DW, 32, data width
MAX_D_BURST, 4, max consecutive D grants while IF is pending (must be >=1)
TIMEOUT, 16, cycles to wait for m_ready before abort (0 = never abort)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
if_req  in  1  fetch request (level)
if_addr  in  AW  fetch address
if_done  out  1  fetch complete pulse
if_rdata  out  DW  fetch data
d_req  in  1  data request (level)
d_rw  in  1  1 = write, 0 = read
d_addr  in  AW  data address
d_wdata  in  DW  store data
d_done  out  1  data complete pulse
d_rdata  out  DW  load data
err  out  1  with a done pulse: access timed out
m_valid  out  1  memory request
m_rw  out  1  memory write enable
m_ready  in  1  memory accepts/completes access
m_addr  out  AW  memory address
m_wdata  out  DW  memory write data
m_rdata  in  DW  memory read data

Behaviour:
- Reset: async on reset_n low, effective immediately. State=IDLE. m_valid, m_rw, if_done, d_done and err are 0. m_addr, m_wdata, if_rdata and d_rdata are 0. Burst and timeout counters are 0. An access in flight is abandoned with no done pulse.
- Requester rule: hold req high with addr/rw/wdata stable until the matching done pulse. Deassert, or present new fields, in the cycle after done.
- FSM IDLE -> ACCESS -> RESP -> IDLE.
- IDLE, arbitration on sampled req:
  - If only one requester is active, it is granted.
  - If both are active, D is granted unless burst_cnt==MAX_D_BURST, in which case IF is granted.
  - On grant: latch owner, m_addr and m_rw; latch m_wdata from d_wdata for D, otherwise hold it. Set m_valid=1 next cycle. Clear tmo_cnt.
- ACCESS:
  - m_valid=1 and all m_* outputs are held constant.
  - On a cycle with m_ready=1: for a read, capture m_rdata into the owner's rdata register. Then m_valid=0 and go to RESP.
  - Otherwise tmo_cnt increments. When TIMEOUT!=0 and tmo_cnt==TIMEOUT-1 with m_ready=0: m_valid=0, err flag set, owner rdata set to 0, go to RESP.
- RESP:
  - Owner's done=1 for exactly this cycle; err=1 only if the access timed out.
  - req is ignored this cycle, so no grant is made here. Return to IDLE.
- Latency: req high in IDLE at cycle 0 -> m_valid high in cycle 1. With m_ready=1 in cycle 1, done pulses in cycle 2. Minimum period is 3 cycles per access.
- Writes leave the owner's rdata unchanged.
- burst_cnt:
  - Increments (saturating at MAX_D_BURST) on each D grant made while if_req=1.
  - Clears on any IF grant.
  - Clears on a D grant made with if_req=0.
- Simultaneous events:
  - m_ready=1 on the same cycle the timeout is reached: the access completes normally with err=0.
  - A request arriving during ACCESS or RESP waits for IDLE.
- Done pulses are mutually exclusive.

Test Plan:
- Single read: IF req addr 0x8, m_ready=1 the cycle after grant, m_rdata=0x00700113 -> m_valid high cycle 1 with m_addr=0x8 and m_rw=0; if_done pulse cycle 2 with if_rdata=0x00700113; err=0.
- Write: D rw=1 addr 0x4 wdata 0x15, m_ready delayed 3 cycles -> m_valid, m_rw=1, m_addr=0x4 and m_wdata=0x15 stable 4 cycles; d_done one cycle after ready; d_rdata unchanged.
- Contention/starvation: both requesters continuously active, MAX_D_BURST=4, m_ready=1 -> grant sequence D,D,D,D,IF,D,D,D,D,IF...; IF never waits more than 4 accesses.
- Timeout: TIMEOUT=16, D read, m_ready held 0 -> m_valid drops after 16 cycles high; d_done=1 with err=1 and d_rdata=0. Repeat with m_ready rising on the 16th cycle -> normal completion, err=0.
- Async reset mid-ACCESS: reset_n low while m_valid=1 -> m_valid=0 immediately; no done pulse; after release, a pending IF req is granted from IDLE.
- RESP ignore: D holds d_req high through done with new addr 0x20 -> no grant in the RESP cycle; next m_valid with m_addr=0x20 starts exactly 2 cycles after the done pulse.
